// File: rtl/cnn_mem_arbiter.sv
// Round-robin arbiter sharing the CNN feature-map memory port between the
// three layer engines, with burst ownership, a burst-length cap and a turnaround gap.
module cnn_mem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 20,
    parameter int SEL_W     = 3,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req,
    input  logic [2:0]          req_last,
    input  logic [2:0]          req_wr,
    input  logic [3*SEL_W-1:0]  req_csel,
    input  logic [3*ADDR_W-1:0] req_addr,
    input  logic [3*DATA_W-1:0] req_wdata,
    output logic [2:0]          gnt,
    output logic                busy,
    output logic [SEL_W-1:0]    csel,
    output logic                cwr,
    output logic                crd,
    output logic [ADDR_W-1:0]   caddr_wr,
    output logic [ADDR_W-1:0]   caddr_rd,
    output logic [DATA_W-1:0]   cdata_wr
);

    // state | meaning
    // IDLE  | no owner, arbitrate on any request
    // OWN   | gnt holds the current owner; beats pass to memory
    // GAP   | one turnaround cycle, memory port idle, then re-arbitrate
    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MAX_BURST - 1);

    state_t      state, state_nxt;
    logic [2:0]  gnt_nxt;
    logic [1:0]  rr_ptr, rr_ptr_nxt;
    logic [7:0]  beat_cnt, beat_cnt_nxt;
    logic [2:0]  win_oh;
    logic [1:0]  owner;
    logic        beat;

    logic              o_last, o_wr;
    logic [SEL_W-1:0]  o_csel;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            rr_ptr   <= 2'd0;
            beat_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // first requester at or after rr_ptr, wrapping mod 3
    always_comb begin
        win_oh = 3'b000;
        case (rr_ptr)
            2'd1: begin
                if      (req[1]) win_oh = 3'b010;
                else if (req[2]) win_oh = 3'b100;
                else if (req[0]) win_oh = 3'b001;
            end
            2'd2: begin
                if      (req[2]) win_oh = 3'b100;
                else if (req[0]) win_oh = 3'b001;
                else if (req[1]) win_oh = 3'b010;
            end
            default: begin
                if      (req[0]) win_oh = 3'b001;
                else if (req[1]) win_oh = 3'b010;
                else if (req[2]) win_oh = 3'b100;
            end
        endcase
    end

    always_comb begin
        owner = 2'd0;
        if (gnt[1]) owner = 2'd1;
        if (gnt[2]) owner = 2'd2;
    end

    always_comb begin
        o_last  = req_last[0];
        o_wr    = req_wr[0];
        o_csel  = req_csel[0 +: SEL_W];
        o_addr  = req_addr[0 +: ADDR_W];
        o_wdata = req_wdata[0 +: DATA_W];
        case (owner)
            2'd1: begin
                o_last  = req_last[1];
                o_wr    = req_wr[1];
                o_csel  = req_csel[SEL_W +: SEL_W];
                o_addr  = req_addr[ADDR_W +: ADDR_W];
                o_wdata = req_wdata[DATA_W +: DATA_W];
            end
            2'd2: begin
                o_last  = req_last[2];
                o_wr    = req_wr[2];
                o_csel  = req_csel[2*SEL_W +: SEL_W];
                o_addr  = req_addr[2*ADDR_W +: ADDR_W];
                o_wdata = req_wdata[2*DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    // gnt is zero outside OWN, so beats can only happen while owning
    assign beat = |(req & gnt);

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            OWN: begin
                if (beat) beat_cnt_nxt = beat_cnt + 8'd1;
                if (!beat || o_last || beat_cnt == CNT_LAST) begin
                    state_nxt = GAP;
                    gnt_nxt   = 3'b000;
                    case (owner)
                        2'd0:    rr_ptr_nxt = 2'd1;
                        2'd1:    rr_ptr_nxt = 2'd2;
                        default: rr_ptr_nxt = 2'd0;
                    endcase
                end
            end
            default: begin
                if (|req) begin
                    state_nxt    = OWN;
                    gnt_nxt      = win_oh;
                    beat_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 3'b000;
                end
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign cwr      = beat & o_wr;
    assign crd      = beat & ~o_wr;
    assign csel     = beat ? o_csel : '0;
    assign caddr_wr = cwr ? o_addr : '0;
    assign caddr_rd = crd ? o_addr : '0;
    assign cdata_wr = cwr ? o_wdata : '0;

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Directed bench for cnn_mem_arbiter: default-cap instance plus a MAX_BURST=4
// instance sharing the same requester stimulus.
module tb_cnn_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 20;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [2:0]      req, req_last, req_wr;
    logic [3*SW-1:0] req_csel;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;

    logic [2:0]    gnt, cap_gnt;
    logic          busy, cwr, crd, cap_busy, cap_cwr, cap_crd;
    logic [SW-1:0] csel, cap_csel;
    logic [AW-1:0] caddr_wr, caddr_rd, cap_caddr_wr, cap_caddr_rd;
    logic [DW-1:0] cdata_wr, cap_cdata_wr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cnn_mem_arbiter u_dut (
        .clk(clk), .reset(reset), .req(req), .req_last(req_last), .req_wr(req_wr),
        .req_csel(req_csel), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .busy(busy), .csel(csel), .cwr(cwr), .crd(crd),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr)
    );

    cnn_mem_arbiter #(.MAX_BURST(4)) u_cap (
        .clk(clk), .reset(reset), .req(req), .req_last(req_last), .req_wr(req_wr),
        .req_csel(req_csel), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(cap_gnt), .busy(cap_busy), .csel(cap_csel), .cwr(cap_cwr), .crd(cap_crd),
        .caddr_wr(cap_caddr_wr), .caddr_rd(cap_caddr_rd), .cdata_wr(cap_cdata_wr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane(input int i, input logic [SW-1:0] cs, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        req_csel[i*SW +: SW]  = cs;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic chk_idle(input string tag, input logic [2:0] g, input logic b);
        chk({tag, "_gnt"}, gnt, g);
        chk({tag, "_busy"}, busy, b);
        chk({tag, "_strb"}, {cwr, crd}, 2'b00);
        chk({tag, "_csel"}, csel, 0);
        chk({tag, "_adwr"}, caddr_wr, 0);
        chk({tag, "_adrd"}, caddr_rd, 0);
        chk({tag, "_data"}, cdata_wr, 0);
    endtask

    task automatic chk_beat(input string tag, input logic [2:0] g, input logic wr,
                            input logic [SW-1:0] sel, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        chk({tag, "_gnt"}, gnt, g);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_cwr"}, cwr, wr);
        chk({tag, "_crd"}, crd, !wr);
        chk({tag, "_csel"}, csel, sel);
        chk({tag, "_adwr"}, caddr_wr, wr ? a : '0);
        chk({tag, "_adrd"}, caddr_rd, wr ? '0 : a);
        chk({tag, "_data"}, cdata_wr, wr ? d : '0);
    endtask

    task automatic do_reset(input bit check_it);
        @(negedge clk);
        reset     = 1'b0;
        req       = '0;
        req_last  = '0;
        req_wr    = '0;
        req_csel  = '0;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        if (check_it) begin
            chk_idle("rst", 3'b000, 1'b0);
            chk("rst_cap_gnt", cap_gnt, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req = '0; req_last = '0; req_wr = '0;
        req_csel = '0; req_addr = '0; req_wdata = '0;

        do_reset(1'b1);

        // single requester, 5-beat write burst closed by req_last
        req = 3'b001; req_wr = 3'b001;
        lane(0, 3'd5, 12'h100, 20'hA0000);
        @(negedge clk); chk_idle("s_lat", 3'b000, 1'b0); step();
        for (int k = 1; k <= 5; k++) begin
            lane(0, 3'd5, 12'(12'h100 + k), 20'(20'hA0000 + k));
            req_last[0] = (k == 5);
            @(negedge clk);
            chk_beat("s_beat", 3'b001, 1'b1, 3'd5, 12'(12'h100 + k), 20'(20'hA0000 + k));
            step();
        end
        req = '0; req_last = '0;
        @(negedge clk); chk_idle("s_gap", 3'b000, 1'b1); step();
        @(negedge clk); chk_idle("s_idle", 3'b000, 1'b0); step();

        // contention with cap of 4: L0, L1, L2, L0
        do_reset(1'b0);
        req = 3'b111; req_wr = 3'b000;
        for (int i = 0; i < 3; i++) lane(i, 3'(i + 1), 12'(12'h200 + i * 16), 20'(i + 7));
        @(negedge clk); chk("c_lat_gnt", cap_gnt, 0); step();
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                chk("c_gnt", cap_gnt, 3'b001 << (g % 3));
                chk("c_strb", {cap_cwr, cap_crd}, 2'b01);
                chk("c_adrd", cap_caddr_rd, 12'h200 + (g % 3) * 16);
                chk("c_csel", cap_csel, (g % 3) + 1);
                step();
            end
            if (g < 3) begin
                @(negedge clk);
                chk("c_gap_gnt", cap_gnt, 0);
                chk("c_gap_busy", cap_busy, 1'b1);
                chk("c_gap_strb", {cap_cwr, cap_crd}, 2'b00);
                chk("c_gap_adrd", cap_caddr_rd, 0);
                step();
            end
        end

        // early drop by L1 with L2 and L0 waiting; L2 must win (rr_ptr=2)
        do_reset(1'b0);
        req = 3'b110;
        lane(0, 3'd1, 12'h300, 20'h1);
        lane(1, 3'd2, 12'h310, 20'h2);
        lane(2, 3'd3, 12'h320, 20'h3);
        @(negedge clk); chk("d_lat_gnt", gnt, 0); step();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); chk_beat("d_l1", 3'b010, 1'b0, 3'd2, 12'h310, 20'h2); step();
        end
        req = 3'b101;
        @(negedge clk); chk_idle("d_drop", 3'b010, 1'b1); step();
        @(negedge clk); chk_idle("d_gap", 3'b000, 1'b1); step();
        req_last[2] = 1'b1;
        @(negedge clk); chk_beat("d_l2", 3'b100, 1'b0, 3'd3, 12'h320, 20'h3); step();
        req_last = '0;
        @(negedge clk); chk_idle("d_gap2", 3'b000, 1'b1); step();
        @(negedge clk); chk_beat("d_l0", 3'b001, 1'b0, 3'd1, 12'h300, 20'h1); step();

        // alternating write/read beats
        do_reset(1'b0);
        req = 3'b001;
        step();
        for (int k = 1; k <= 4; k++) begin
            req_wr[0] = k[0];
            lane(0, 3'd2, 12'(12'h400 + k), 20'(20'h4000 + k));
            @(negedge clk);
            chk_beat("x_beat", 3'b001, k[0], 3'd2, 12'(12'h400 + k), 20'(20'h4000 + k));
            step();
        end

        // reset on beat 3 of an L0 write burst, then L1 alone
        do_reset(1'b0);
        req = 3'b001; req_wr = 3'b001;
        step();
        for (int k = 1; k <= 3; k++) begin
            lane(0, 3'd4, 12'(12'h500 + k), 20'(20'h5000 + k));
            @(negedge clk);
            chk_beat("r_beat", 3'b001, 1'b1, 3'd4, 12'(12'h500 + k), 20'(20'h5000 + k));
            if (k < 3) step();
        end
        #1 reset = 1'b0;
        #1;
        chk("r_gnt", gnt, 0);
        chk("r_cwr", cwr, 0);
        chk("r_busy", busy, 0);
        chk("r_adwr", caddr_wr, 0);
        @(negedge clk);
        reset = 1'b1;
        req = 3'b010; req_wr = 3'b000;
        lane(1, 3'd6, 12'h510, 20'h0);
        step();
        @(negedge clk); chk_beat("r_l1", 3'b010, 1'b0, 3'd6, 12'h510, 20'h0); step();

        // L2 noise on last/wdata/wr while L0 owns
        do_reset(1'b0);
        req = 3'b001; req_wr = 3'b101;
        step();
        for (int k = 1; k <= 4; k++) begin
            lane(0, 3'd1, 12'(12'h600 + k), 20'(20'h6000 + k));
            lane(2, 3'd7, 12'hFFF, 20'($urandom));
            req_last[2] = k[0];
            req_last[0] = (k == 4);
            @(negedge clk);
            chk_beat("n_beat", 3'b001, 1'b1, 3'd1, 12'(12'h600 + k), 20'(20'h6000 + k));
            step();
        end
        req = '0; req_last = '0;
        @(negedge clk); chk_idle("n_gap", 3'b000, 1'b1); step();
        @(negedge clk); chk_idle("n_idle", 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
